seg_decode_hazard: RTL and testbench
====================================

Name: seg_decode_hazard

Overview:
Parametrised next-generation MIPS instruction-decode stage with an integrated register file and ID/EX pipeline register. Adds a load-use and branch hazard unit driven by a stall FSM, and resolves branches and jumps in ID using MEM-stage forwarding. It sits between the IF/ID register and the EX stage, and feeds stall/jump back to IF.

Parameters:
LEN, 32, datapath and PC width
N_REGS, 32, register count (power of 2)
NB_ADDR, 5, register address width (log2 N_REGS)
NB_IMM, 16, immediate field width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_enable  in  1  pipeline enable; 0 freezes all state
i_flush  in  1  IF/ID content invalid; inject bubble
i_pc  in  LEN  PC+4 of instruction in ID
i_instruction  in  32  instruction in ID
i_wb_we  in  1  WB register write
i_wb_reg  in  NB_ADDR  WB destination
i_wb_data  in  LEN  WB data
i_ex_regwrite  in  1  EX instr writes a register
i_ex_memread  in  1  EX instr is a load
i_ex_wreg  in  NB_ADDR  EX destination
i_mem_regwrite  in  1  MEM instr writes a register
i_mem_memread  in  1  MEM instr is a load
i_mem_wreg  in  NB_ADDR  MEM destination
i_mem_fwd_data  in  LEN  MEM ALU result
o_stall  out  1  hold PC and IF/ID (combinational)
o_jump_flag  out  1  redirect PC (combinational)
o_pc_target  out  LEN  redirect address (combinational)
o_pc, o_imm_ext, o_rd_data_1, o_rd_data_2  out  LEN  registered ID/EX data
o_rs, o_rt, o_rd  out  NB_ADDR  registered fields; o_rd=31 for JAL, rd for JALR
o_ctrl_ex  out  6  {RegDst[1:0], ALUSrc, ALUOp[2:0]}
o_ctrl_mem  out  5  {MemRead, MemWrite, Unsigned, Size[1:0]}
o_ctrl_wb  out  3  {RegWrite, WbSel[1:0]}: 00 ALU, 01 MEM, 10 PC link

Behaviour:
- One clock (i_clk); reset (i_rst) synchronous, active-high. Reset clears all registered outputs, all N_REGS registers and the FSM (IDLE, cnt=0).
- Edge priority: i_rst > !i_enable (hold everything, regfile writes blocked) > i_flush (bubble, FSM→IDLE) > stall (bubble) > normal load.
- Bubble: all ctrl and data outputs zero.
- Register file: reg 0 reads 0 and ignores writes. Write at posedge when i_wb_we && i_enable. Same-cycle read of the register being written returns i_wb_data.
- Branch/JR operand source: MEM forward if i_mem_regwrite && !i_mem_memread && i_mem_wreg==reg!=0; else the regfile path.
- ALUOp encoding: 000 ADD, 001 FUNCT, 010 SUB, 011 AND, 100 OR, 101 SLT, 110 LUI.
- Decoded instructions: R-type (incl. JR/JALR), LB/LH/LW/LWU/LBU/LHU, SB/SH/SW, ADDI/ANDI/ORI/SLTI/LUI, BEQ/BNE, J/JAL. Any other opcode decodes to a bubble.
- Immediate extension: ANDI/ORI zero-extend, all others sign-extend.
- Operand use: rs is used by everything except J/JAL/LUI. rt is used by R-type (except JR/JALR), stores and BEQ/BNE.
- Hazard cycles h:
  - 2: branch/JR/JALR operand == i_ex_wreg with i_ex_memread.
  - 1: branch/JR/JALR operand == i_ex_wreg with i_ex_regwrite; or branch/JR/JALR operand == i_mem_wreg with i_mem_memread; or any used operand == i_ex_wreg with i_ex_memread.
  - 0: otherwise.
  - Register 0 never causes a hazard.
- FSM:
  - IDLE: if h>0 then o_stall=1 and a bubble is loaded; go to STALL with cnt=h-1 if h==2, else stay IDLE.
  - STALL: o_stall=1, bubble loaded, cnt decrements; IDLE when cnt reaches 0.
  - Transitions only when i_enable. i_flush forces IDLE, cnt=0.
- o_stall and o_jump_flag are forced 0 when i_flush or i_rst.
- o_jump_flag=1 only when o_stall=0:
  - J/JAL: target {i_pc[31:28], instr[25:0], 00}.
  - JR/JALR: target = forwarded rs.
  - BEQ/BNE: taken if operands are equal/unequal; target i_pc + (sext(imm)<<2), modulo 2^LEN.
- JAL/JALR: ctrl_wb=3'b110; link value is o_pc (PC+4).

Test Plan:
- Reset: i_rst=1 for one edge → all outputs 0, regs[1..31]=0, o_stall=0.
- Regfile bypass: i_wb_we=1, reg2=0x0000ABCD, ID=ADDU rs=2 in same cycle → next edge o_rd_data_1=0x0000ABCD. Write to reg0 then read → 0.
- Load-use: EX load to $8, ID=0x010A4820 (ADD $9,$8,$10) → o_stall=1 for 1 cycle with ID/EX bubble, then ctrl_ex=6'b01_0_001.
- Branch after load: EX LW to $8, ID BEQ $8,$9 imm=4, i_pc=0x100 → o_stall 2 cycles. Then with MEM forward $8==$9 → o_jump_flag=1, o_pc_target=0x110.
- JAL: i_pc=0x00400008, instr=0x0C000010 → o_jump_flag=1, target=0x00000040; next edge o_rd=31, o_ctrl_wb=3'b110, o_pc=0x00400008.
- Freeze/flush: i_enable=0 during STALL → outputs and cnt hold. i_flush=1 during STALL → bubble, FSM IDLE, o_stall=0.

Source files
------------

// File: rtl/seg_decode_hazard_if.sv
// rtl/seg_decode_hazard_if.sv - ID-stage bus bundle for seg_decode_hazard
interface seg_decode_hazard_if #(
   parameter int LEN     = 32,
   parameter int NB_ADDR = 5
);
   logic               i_enable;
   logic               i_flush;
   logic [LEN-1:0]     i_pc;
   logic [31:0]        i_instruction;
   logic               i_wb_we;
   logic [NB_ADDR-1:0] i_wb_reg;
   logic [LEN-1:0]     i_wb_data;
   logic               i_ex_regwrite;
   logic               i_ex_memread;
   logic [NB_ADDR-1:0] i_ex_wreg;
   logic               i_mem_regwrite;
   logic               i_mem_memread;
   logic [NB_ADDR-1:0] i_mem_wreg;
   logic [LEN-1:0]     i_mem_fwd_data;
   logic               o_stall;
   logic               o_jump_flag;
   logic [LEN-1:0]     o_pc_target;
   logic [LEN-1:0]     o_pc;
   logic [LEN-1:0]     o_imm_ext;
   logic [LEN-1:0]     o_rd_data_1;
   logic [LEN-1:0]     o_rd_data_2;
   logic [NB_ADDR-1:0] o_rs;
   logic [NB_ADDR-1:0] o_rt;
   logic [NB_ADDR-1:0] o_rd;
   logic [5:0]         o_ctrl_ex;
   logic [4:0]         o_ctrl_mem;
   logic [2:0]         o_ctrl_wb;

   modport master (
      output i_enable, i_flush, i_pc, i_instruction, i_wb_we, i_wb_reg, i_wb_data,
             i_ex_regwrite, i_ex_memread, i_ex_wreg,
             i_mem_regwrite, i_mem_memread, i_mem_wreg, i_mem_fwd_data,
      input  o_stall, o_jump_flag, o_pc_target, o_pc, o_imm_ext, o_rd_data_1, o_rd_data_2,
             o_rs, o_rt, o_rd, o_ctrl_ex, o_ctrl_mem, o_ctrl_wb
   );

   modport slave (
      input  i_enable, i_flush, i_pc, i_instruction, i_wb_we, i_wb_reg, i_wb_data,
             i_ex_regwrite, i_ex_memread, i_ex_wreg,
             i_mem_regwrite, i_mem_memread, i_mem_wreg, i_mem_fwd_data,
      output o_stall, o_jump_flag, o_pc_target, o_pc, o_imm_ext, o_rd_data_1, o_rd_data_2,
             o_rs, o_rt, o_rd, o_ctrl_ex, o_ctrl_mem, o_ctrl_wb
   );
endinterface

// File: rtl/seg_decode_hazard.sv
// rtl/seg_decode_hazard.sv - MIPS decode stage with regfile, hazard FSM, ID branch resolve and ID/EX register
module seg_decode_hazard #(
   parameter int LEN     = 32,
   parameter int N_REGS  = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_IMM  = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   seg_decode_hazard_if.slave bus
);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_STALL = 1'b1;

   logic [LEN-1:0]     regs [N_REGS];
   logic [0:0]         state;
   logic [1:0]         cnt;

   logic [5:0]         op, funct;
   logic [NB_ADDR-1:0] rs, rt, rd;
   logic [NB_IMM-1:0]  imm;
   logic [LEN-1:0]     imm_sext, imm_ext;

   assign op    = bus.i_instruction[31:26];
   assign funct = bus.i_instruction[5:0];
   assign rs    = NB_ADDR'(bus.i_instruction[25:21]);
   assign rt    = NB_ADDR'(bus.i_instruction[20:16]);
   assign rd    = NB_ADDR'(bus.i_instruction[15:11]);
   assign imm   = bus.i_instruction[NB_IMM-1:0];

   logic       valid, is_jr, is_jal, is_jump, is_branch, use_rs, use_rt, zero_ext;
   logic [5:0] ctrl_ex;
   logic [4:0] ctrl_mem;
   logic [2:0] ctrl_wb;

   always_comb begin
      valid     = 1'b1;
      is_jr     = 1'b0;
      is_jal    = 1'b0;
      is_jump   = 1'b0;
      is_branch = 1'b0;
      use_rs    = 1'b1;
      use_rt    = 1'b0;
      zero_ext  = 1'b0;
      ctrl_ex   = 6'b00_0_000;
      ctrl_mem  = 5'b0_0_0_00;
      ctrl_wb   = 3'b0_00;
      case (op)
         6'b000000: begin
            if (funct == 6'b001000 || funct == 6'b001001) begin
               is_jr = 1'b1;
               if (funct[0]) begin
                  ctrl_ex = 6'b01_0_000;
                  ctrl_wb = 3'b1_10;
               end
            end else begin
               use_rt  = 1'b1;
               ctrl_ex = 6'b01_0_001;
               ctrl_wb = 3'b1_00;
            end
         end
         // Loads/stores: op[2] marks unsigned, op[1:0]==11 means a full word.
         6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
            ctrl_ex  = 6'b00_1_000;
            ctrl_mem = {2'b10, op[2], (op[1:0] == 2'b11) ? 2'b10 : op[1:0]};
            ctrl_wb  = 3'b1_01;
         end
         6'b101000, 6'b101001, 6'b101011: begin
            use_rt   = 1'b1;
            ctrl_ex  = 6'b00_1_000;
            ctrl_mem = {3'b010, (op[1:0] == 2'b11) ? 2'b10 : op[1:0]};
         end
         6'b001000: begin ctrl_ex = 6'b00_1_000; ctrl_wb = 3'b1_00; end
         6'b001010: begin ctrl_ex = 6'b00_1_101; ctrl_wb = 3'b1_00; end
         6'b001100: begin ctrl_ex = 6'b00_1_011; ctrl_wb = 3'b1_00; zero_ext = 1'b1; end
         6'b001101: begin ctrl_ex = 6'b00_1_100; ctrl_wb = 3'b1_00; zero_ext = 1'b1; end
         6'b001111: begin ctrl_ex = 6'b00_1_110; ctrl_wb = 3'b1_00; use_rs = 1'b0; end
         6'b000100, 6'b000101: begin
            is_branch = 1'b1;
            use_rt    = 1'b1;
            ctrl_ex   = 6'b00_0_010;
         end
         6'b000010: begin is_jump = 1'b1; use_rs = 1'b0; end
         6'b000011: begin
            is_jump = 1'b1;
            is_jal  = 1'b1;
            use_rs  = 1'b0;
            ctrl_ex = 6'b10_0_000;
            ctrl_wb = 3'b1_10;
         end
         default: begin valid = 1'b0; use_rs = 1'b0; end
      endcase
   end

   assign imm_sext = {{(LEN-NB_IMM){imm[NB_IMM-1]}}, imm};
   assign imm_ext  = zero_ext ? {{(LEN-NB_IMM){1'b0}}, imm} : imm_sext;

   // Read ports see the value being written back this cycle.
   logic           wb_on, mem_fwd_ok;
   logic [LEN-1:0] rf_rs, rf_rt, op_rs, op_rt;

   assign wb_on = bus.i_wb_we && bus.i_enable && (bus.i_wb_reg != '0);
   assign rf_rs = (rs == '0) ? '0 : (wb_on && bus.i_wb_reg == rs) ? bus.i_wb_data : regs[rs];
   assign rf_rt = (rt == '0) ? '0 : (wb_on && bus.i_wb_reg == rt) ? bus.i_wb_data : regs[rt];

   assign mem_fwd_ok = bus.i_mem_regwrite && !bus.i_mem_memread;
   assign op_rs = (mem_fwd_ok && rs != '0 && bus.i_mem_wreg == rs) ? bus.i_mem_fwd_data : rf_rs;
   assign op_rt = (mem_fwd_ok && rt != '0 && bus.i_mem_wreg == rt) ? bus.i_mem_fwd_data : rf_rt;

   logic       br_rs, br_rt, rs_live, rt_live, ex_rs, ex_rt, mem_rs, mem_rt;
   logic [1:0] haz;

   assign br_rs   = (is_branch || is_jr) && rs != '0;
   assign br_rt   = is_branch && rt != '0;
   assign rs_live = use_rs && rs != '0;
   assign rt_live = use_rt && rt != '0;
   assign ex_rs   = bus.i_ex_wreg == rs;
   assign ex_rt   = bus.i_ex_wreg == rt;
   assign mem_rs  = bus.i_mem_wreg == rs;
   assign mem_rt  = bus.i_mem_wreg == rt;

   always_comb begin
      haz = 2'd0;
      if ((br_rs && ex_rs) || (br_rt && ex_rt)) begin
         if (bus.i_ex_memread)
            haz = 2'd2;
         else if (bus.i_ex_regwrite)
            haz = 2'd1;
      end
      if (haz == 2'd0 &&
          ((bus.i_mem_memread && ((br_rs && mem_rs) || (br_rt && mem_rt))) ||
           (bus.i_ex_memread && ((rs_live && ex_rs) || (rt_live && ex_rt)))))
         haz = 2'd1;
   end

   logic stall_int, taken, load_bubble;

   assign stall_int = (state == S_STALL) || (haz != 2'd0);
   assign taken     = is_jump || is_jr || (is_branch && ((op_rs == op_rt) ^ op[0]));
   assign load_bubble = bus.i_flush || stall_int || !valid;

   assign bus.o_stall     = !i_rst && !bus.i_flush && stall_int;
   assign bus.o_jump_flag = !i_rst && !bus.i_flush && !stall_int && taken;
   assign bus.o_pc_target = is_jump ? {bus.i_pc[LEN-1:28], bus.i_instruction[25:0], 2'b00} :
                            is_jr   ? op_rs :
                                      bus.i_pc + {imm_sext[LEN-3:0], 2'b00};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < N_REGS; i++)
            regs[i] <= '0;
      end else if (wb_on) begin
         regs[bus.i_wb_reg] <= bus.i_wb_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= S_IDLE;
         cnt             <= 2'd0;
         bus.o_pc        <= '0;
         bus.o_imm_ext   <= '0;
         bus.o_rd_data_1 <= '0;
         bus.o_rd_data_2 <= '0;
         bus.o_rs        <= '0;
         bus.o_rt        <= '0;
         bus.o_rd        <= '0;
         bus.o_ctrl_ex   <= '0;
         bus.o_ctrl_mem  <= '0;
         bus.o_ctrl_wb   <= '0;
      end else if (bus.i_enable) begin
         if (bus.i_flush) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
         end else if (state == S_STALL) begin
            if (cnt <= 2'd1) begin
               state <= S_IDLE;
               cnt   <= 2'd0;
            end else begin
               cnt <= cnt - 2'd1;
            end
         end else if (haz == 2'd2) begin
            state <= S_STALL;
            cnt   <= haz - 2'd1;
         end
         bus.o_pc        <= load_bubble ? '0 : bus.i_pc;
         bus.o_imm_ext   <= load_bubble ? '0 : imm_ext;
         bus.o_rd_data_1 <= load_bubble ? '0 : rf_rs;
         bus.o_rd_data_2 <= load_bubble ? '0 : rf_rt;
         bus.o_rs        <= load_bubble ? '0 : rs;
         bus.o_rt        <= load_bubble ? '0 : rt;
         bus.o_rd        <= load_bubble ? '0 : (is_jal ? {NB_ADDR{1'b1}} : rd);
         bus.o_ctrl_ex   <= load_bubble ? '0 : ctrl_ex;
         bus.o_ctrl_mem  <= load_bubble ? '0 : ctrl_mem;
         bus.o_ctrl_wb   <= load_bubble ? '0 : ctrl_wb;
      end
   end
endmodule

// File: tb/tb_seg_decode_hazard.sv
// tb/tb_seg_decode_hazard.sv - randomized self-checking bench for seg_decode_hazard
module tb_seg_decode_hazard;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [31:0] mreg [32];

   localparam int K_ADD = 0, K_JR = 1, K_JALR = 2, K_LW = 3, K_SW = 4;
   localparam int K_ADDI = 5, K_LUI = 6, K_BEQ = 7, K_BNE = 8, K_J = 9;

   seg_decode_hazard_if #(.LEN(32), .NB_ADDR(5)) bus ();

   seg_decode_hazard #(.LEN(32), .N_REGS(32), .NB_ADDR(5), .NB_IMM(16)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   // Stall cycles required, derived from the operand-use and hazard rules.
   function automatic int exp_hazard(int kind, int rs, int rt, bit exrw, bit exmr, int exw,
                                     bit memmr, int memw);
      bit br    = kind inside {K_JR, K_JALR, K_BEQ, K_BNE};
      bit br2   = kind inside {K_BEQ, K_BNE};
      bit u_rs  = !(kind inside {K_J, K_LUI});
      bit u_rt  = kind inside {K_ADD, K_SW, K_BEQ, K_BNE};
      int h = 0;
      for (int k = 0; k < 2; k++) begin
         int r = (k == 0) ? rs : rt;
         bit u = (k == 0) ? u_rs : u_rt;
         bit b = (k == 0) ? br : br2;
         if (r != 0) begin
            if (b && exmr && r == exw) h = 2;
            if (h < 2 && ((b && exrw && r == exw) || (b && memmr && r == memw) || (u && exmr && r == exw)))
               h = 1;
         end
      end
      return h;
   endfunction

   task automatic step;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle;
      bus.i_enable = 1'b1;       bus.i_flush = 1'b0;
      bus.i_pc = 32'h0;          bus.i_instruction = 32'hFC00_0000;
      bus.i_wb_we = 1'b0;        bus.i_wb_reg = 5'd0;      bus.i_wb_data = 32'h0;
      bus.i_ex_regwrite = 1'b0;  bus.i_ex_memread = 1'b0;  bus.i_ex_wreg = 5'd0;
      bus.i_mem_regwrite = 1'b0; bus.i_mem_memread = 1'b0; bus.i_mem_wreg = 5'd0;
      bus.i_mem_fwd_data = 32'h0;
   endtask

   task automatic settle;
      idle();
      bus.i_flush = 1'b1;
      step();
      bus.i_flush = 1'b0;
   endtask

   task automatic wb_write(int r, logic [31:0] d);
      bus.i_wb_we = 1'b1; bus.i_wb_reg = 5'(r); bus.i_wb_data = d;
      step();
      if (r != 0) mreg[r] = d;
      bus.i_wb_we = 1'b0;
   endtask

   task automatic test_reset;
      logic [156:0] all_out;
      idle();
      step();
      i_rst = 1'b0;
      for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
      wb_write(5, 32'h1234_5678);
      bus.i_instruction = r_ins(5, 5, 3, 6'h21);
      step();
      i_rst = 1'b1;
      bus.i_ex_memread = 1'b1; bus.i_ex_wreg = 5'd5;
      step();
      all_out = {bus.o_pc, bus.o_imm_ext, bus.o_rd_data_1, bus.o_rd_data_2, bus.o_rs, bus.o_rt,
                 bus.o_rd, bus.o_ctrl_ex, bus.o_ctrl_mem, bus.o_ctrl_wb};
      checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", all_out); end
      checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", bus.o_stall); end
      i_rst = 1'b0;
      #1;
      checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL post_reset_stall got=%b want=1", bus.o_stall); end
      idle();
      for (int r = 1; r < 32; r++) begin
         bus.i_instruction = r_ins(r, 0, 1, 6'h21);
         step();
         checks++;
         if (bus.o_rd_data_1 !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h want=0", r, bus.o_rd_data_1); end
      end
   endtask

   task automatic test_regfile;
      settle();
      bus.i_wb_we = 1'b1; bus.i_wb_reg = 5'd2; bus.i_wb_data = 32'h0000_ABCD;
      bus.i_instruction = r_ins(2, 0, 4, 6'h21);
      step();
      mreg[2] = 32'h0000_ABCD;
      checks++; if (bus.o_rd_data_1 !== 32'h0000_ABCD) begin failures++; $display("FAIL bypass got=%h want=0000abcd", bus.o_rd_data_1); end
      bus.i_wb_reg = 5'd0; bus.i_wb_data = 32'hFFFF_FFFF; bus.i_instruction = r_ins(0, 0, 4, 6'h21);
      step();
      checks++; if (bus.o_rd_data_1 !== 32'h0) begin failures++; $display("FAIL reg0_bypass got=%h want=0", bus.o_rd_data_1); end
      bus.i_wb_we = 1'b0;
      step();
      checks++; if (bus.o_rd_data_1 !== 32'h0) begin failures++; $display("FAIL reg0_read got=%h want=0", bus.o_rd_data_1); end
      for (int n = 0; n < 24; n++) begin
         int w = $urandom_range(0, 31), a = $urandom_range(0, 31), b = $urandom_range(0, 31);
         int d = $urandom_range(1, 31);
         logic [31:0] val = $urandom();
         bus.i_wb_we = 1'b1; bus.i_wb_reg = 5'(w); bus.i_wb_data = val;
         bus.i_instruction = r_ins((n % 3 == 0) ? w : a, b, d, 6'h21);
         step();
         if (w != 0) mreg[w] = val;
         if (n % 3 == 0) a = w;
         checks++;
         if (bus.o_rd_data_1 !== mreg[a] || bus.o_rd_data_2 !== mreg[b] || bus.o_rd !== 5'(d) || bus.o_ctrl_ex !== 6'b01_0_001)
            begin failures++; $display("FAIL regfile_rand n=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/010001", n,
               bus.o_rd_data_1, bus.o_rd_data_2, bus.o_rd, bus.o_ctrl_ex, mreg[a], mreg[b], d); end
      end
      bus.i_wb_we = 1'b0;
   endtask

   task automatic test_imm;
      logic [5:0] ops [5] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
      logic [5:0] exs [5] = '{6'b001000, 6'b001101, 6'b001011, 6'b001100, 6'b001110};
      settle();
      for (int n = 0; n < 10; n++) begin
         int k = $urandom_range(0, 4);
         logic [15:0] imm = 16'($urandom());
         logic [31:0] e;
         if (n < 5) k = n;
         if (n == 2 || n == 3) imm[15] = 1'b1;
         e = (k == 2 || k == 3) ? {16'h0, imm} : 32'(int'(shortint'(imm)));
         bus.i_instruction = i_ins(ops[k], 1, 2, imm);
         step();
         checks++;
         if (bus.o_imm_ext !== e || bus.o_ctrl_ex !== exs[k] || bus.o_ctrl_wb !== 3'b100)
            begin failures++; $display("FAIL imm_ext op=%h got=%h/%b want=%h/%b", ops[k], bus.o_imm_ext, bus.o_ctrl_ex, e, exs[k]); end
      end
   endtask

   task automatic test_load_use;
      settle();
      bus.i_ex_memread = 1'b1; bus.i_ex_regwrite = 1'b1; bus.i_ex_wreg = 5'd8;
      bus.i_instruction = 32'h010A_4820;
      #1;
      checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%b want=1", bus.o_stall); end
      step();
      checks++; if (bus.o_ctrl_ex !== 6'b0) begin failures++; $display("FAIL load_use_bubble got=%b want=0", bus.o_ctrl_ex); end
      bus.i_ex_memread = 1'b0; bus.i_ex_regwrite = 1'b0;
      #1;
      checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b want=0", bus.o_stall); end
      step();
      checks++; if (bus.o_ctrl_ex !== 6'b01_0_001) begin failures++; $display("FAIL load_use_issue got=%b want=010001", bus.o_ctrl_ex); end
   endtask

   task automatic test_hazard_random;
      for (int n = 0; n < 40; n++) begin
         int kind = $urandom_range(0, 9), rs = $urandom_range(0, 3), rt = $urandom_range(0, 3);
         int exw = $urandom_range(0, 3), memw = $urandom_range(0, 3), h;
         bit exrw = 1'($urandom()), exmr = 1'($urandom()), memmr = 1'($urandom());
         logic [15:0] imm = 16'($urandom());
         settle();
         case (kind)
            K_ADD:   bus.i_instruction = r_ins(rs, rt, 3, 6'h20);
            K_JR:    bus.i_instruction = r_ins(rs, rt, 0, 6'h08);
            K_JALR:  bus.i_instruction = r_ins(rs, rt, 31, 6'h09);
            K_LW:    bus.i_instruction = i_ins(6'h23, rs, rt, imm);
            K_SW:    bus.i_instruction = i_ins(6'h2B, rs, rt, imm);
            K_ADDI:  bus.i_instruction = i_ins(6'h08, rs, rt, imm);
            K_LUI:   bus.i_instruction = i_ins(6'h0F, rs, rt, imm);
            K_BEQ:   bus.i_instruction = i_ins(6'h04, rs, rt, imm);
            K_BNE:   bus.i_instruction = i_ins(6'h05, rs, rt, imm);
            default: bus.i_instruction = i_ins(6'h02, rs, rt, imm);
         endcase
         bus.i_ex_regwrite = exrw; bus.i_ex_memread = exmr; bus.i_ex_wreg = 5'(exw);
         bus.i_mem_memread = memmr; bus.i_mem_wreg = 5'(memw);
         h = exp_hazard(kind, rs, rt, exrw, exmr, exw, memmr, memw);
         #1;
         checks++;
         if (bus.o_stall !== (h > 0) || (h > 0 && bus.o_jump_flag !== 1'b0))
            begin failures++; $display("FAIL hazard n=%0d kind=%0d got=%b/%b want h=%0d", n, kind, bus.o_stall, bus.o_jump_flag, h); end
         step();
         bus.i_ex_regwrite = 1'b0; bus.i_ex_memread = 1'b0; bus.i_mem_memread = 1'b0;
         #1;
         checks++;
         if (bus.o_stall !== (h == 2) || (h > 0 && bus.o_ctrl_ex !== 6'b0))
            begin failures++; $display("FAIL hazard_hold n=%0d got=%b/%b want h=%0d", n, bus.o_stall, bus.o_ctrl_ex, h); end
      end
   endtask

   task automatic test_branch_after_load;
      settle();
      wb_write(8, 32'h11);
      wb_write(9, 32'h22);
      bus.i_instruction = i_ins(6'h04, 8, 9, 16'd4); bus.i_pc = 32'h100;
      bus.i_ex_memread = 1'b1; bus.i_ex_regwrite = 1'b1; bus.i_ex_wreg = 5'd8;
      #1;
      checks++; if (bus.o_stall !== 1'b1 || bus.o_jump_flag !== 1'b0) begin failures++; $display("FAIL br_load_stall1 got=%b/%b want=1/0", bus.o_stall, bus.o_jump_flag); end
      step();
      bus.i_ex_memread = 1'b0; bus.i_ex_regwrite = 1'b0;
      #1;
      checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL br_load_stall2 got=%b want=1", bus.o_stall); end
      step();
      checks++; if (bus.o_stall !== 1'b0 || bus.o_jump_flag !== 1'b0) begin failures++; $display("FAIL br_not_taken got=%b/%b want=0/0", bus.o_stall, bus.o_jump_flag); end
      bus.i_mem_regwrite = 1'b1; bus.i_mem_wreg = 5'd8; bus.i_mem_fwd_data = 32'h22;
      #1;
      checks++; if (bus.o_jump_flag !== 1'b1 || bus.o_pc_target !== 32'h110) begin failures++; $display("FAIL br_fwd_taken got=%b/%h want=1/00000110", bus.o_jump_flag, bus.o_pc_target); end
      bus.i_mem_memread = 1'b1;
      #1;
      checks++; if (bus.o_stall !== 1'b1 || bus.o_jump_flag !== 1'b0) begin failures++; $display("FAIL br_mem_load got=%b/%b want=1/0", bus.o_stall, bus.o_jump_flag); end
   endtask

   task automatic test_branch_random;
      for (int n = 0; n < 20; n++) begin
         int sel = $urandom_range(0, 3), rs = $urandom_range(1, 31), rt = $urandom_range(1, 31);
         int fsel = $urandom_range(0, 2);
         logic [31:0] pc = $urandom() & 32'hFFFF_FFFC, fd, a, b, tgt;
         logic [15:0] imm = 16'($urandom());
         logic [25:0] idx = 26'($urandom());
         bit jmp;
         settle();
         bus.i_pc = pc;
         bus.i_mem_regwrite = (fsel != 0);
         bus.i_mem_wreg = 5'((fsel == 1) ? rs : rt);
         fd = $urandom_range(0, 1) ? ((fsel == 1) ? mreg[rt] : mreg[rs]) : $urandom();
         bus.i_mem_fwd_data = fd;
         a = (fsel != 0 && rs == ((fsel == 1) ? rs : rt)) ? fd : mreg[rs];
         b = (fsel != 0 && rt == ((fsel == 1) ? rs : rt)) ? fd : mreg[rt];
         case (sel)
            0: begin bus.i_instruction = i_ins(6'h04, rs, rt, imm); jmp = (a == b); end
            1: begin bus.i_instruction = i_ins(6'h05, rs, rt, imm); jmp = (a != b); end
            2: begin bus.i_instruction = r_ins(rs, rt, 0, 6'h08); jmp = 1'b1; end
            default: begin bus.i_instruction = {6'h02, idx}; jmp = 1'b1; end
         endcase
         tgt = (sel == 2) ? a : (sel == 3) ? ((pc & 32'hF000_0000) | (32'(idx) << 2))
                                           : pc + 32'(int'(shortint'(imm)) * 4);
         #1;
         checks++;
         if (bus.o_jump_flag !== jmp || (jmp && bus.o_pc_target !== tgt))
            begin failures++; $display("FAIL branch_rand n=%0d sel=%0d got=%b/%h want=%b/%h", n, sel, bus.o_jump_flag, bus.o_pc_target, jmp, tgt); end
      end
   endtask

   task automatic test_jal;
      settle();
      bus.i_pc = 32'h0040_0008; bus.i_instruction = 32'h0C00_0010;
      #1;
      checks++; if (bus.o_jump_flag !== 1'b1 || bus.o_pc_target !== 32'h40) begin failures++; $display("FAIL jal_jump got=%b/%h want=1/00000040", bus.o_jump_flag, bus.o_pc_target); end
      step();
      checks++; if (bus.o_rd !== 5'd31 || bus.o_ctrl_wb !== 3'b110 || bus.o_pc !== 32'h0040_0008)
         begin failures++; $display("FAIL jal_link got=%0d/%b/%h want=31/110/00400008", bus.o_rd, bus.o_ctrl_wb, bus.o_pc); end
      bus.i_instruction = r_ins(4, 0, 12, 6'h09);
      step();
      checks++; if (bus.o_rd !== 5'd12 || bus.o_ctrl_wb !== 3'b110) begin failures++; $display("FAIL jalr_link got=%0d/%b want=12/110", bus.o_rd, bus.o_ctrl_wb); end
   endtask

   task automatic test_freeze_flush;
      settle();
      bus.i_instruction = r_ins(2, 3, 7, 6'h21); bus.i_pc = 32'h44;
      step();
      bus.i_enable = 1'b0; bus.i_instruction = i_ins(6'h0D, 1, 1, 16'h5555); bus.i_pc = 32'h88;
      bus.i_wb_we = 1'b1; bus.i_wb_reg = 5'd3; bus.i_wb_data = ~mreg[3];
      step(); step();
      checks++; if (bus.o_pc !== 32'h44 || bus.o_rd !== 5'd7 || bus.o_ctrl_ex !== 6'b01_0_001)
         begin failures++; $display("FAIL freeze_hold got=%h/%0d/%b want=00000044/7/010001", bus.o_pc, bus.o_rd, bus.o_ctrl_ex); end
      bus.i_enable = 1'b1; bus.i_wb_we = 1'b0; bus.i_instruction = r_ins(3, 0, 7, 6'h21);
      step();
      checks++; if (bus.o_rd_data_1 !== mreg[3]) begin failures++; $display("FAIL freeze_nowrite got=%h want=%h", bus.o_rd_data_1, mreg[3]); end
      bus.i_instruction = r_ins(8, 0, 0, 6'h08); bus.i_ex_memread = 1'b1; bus.i_ex_wreg = 5'd8;
      step();
      bus.i_ex_memread = 1'b0; bus.i_enable = 1'b0;
      step(); step();
      checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL freeze_stall got=%b want=1", bus.o_stall); end
      bus.i_enable = 1'b1;
      #1;
      checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL freeze_cnt_hold got=%b want=1", bus.o_stall); end
      step();
      checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL freeze_release got=%b want=0", bus.o_stall); end
      bus.i_ex_memread = 1'b1;
      step();
      bus.i_ex_memread = 1'b0; bus.i_flush = 1'b1;
      #1;
      checks++; if (bus.o_stall !== 1'b0 || bus.o_jump_flag !== 1'b0) begin failures++; $display("FAIL flush_force got=%b/%b want=0/0", bus.o_stall, bus.o_jump_flag); end
      step();
      bus.i_flush = 1'b0;
      #1;
      checks++; if (bus.o_stall !== 1'b0 || bus.o_ctrl_ex !== 6'b0 || bus.o_pc !== 32'h0)
         begin failures++; $display("FAIL flush_idle got=%b/%b/%h want=0/0/0", bus.o_stall, bus.o_ctrl_ex, bus.o_pc); end
   endtask

   task automatic test_bad_opcode;
      logic [156:0] all_out;
      settle();
      bus.i_instruction = r_ins(2, 3, 7, 6'h21); bus.i_pc = 32'h4C;
      step();
      bus.i_instruction = i_ins(6'h10, 2, 3, 16'h1234); bus.i_pc = 32'h50;
      step();
      all_out = {bus.o_pc, bus.o_imm_ext, bus.o_rd_data_1, bus.o_rd_data_2, bus.o_rs, bus.o_rt,
                 bus.o_rd, bus.o_ctrl_ex, bus.o_ctrl_mem, bus.o_ctrl_wb};
      checks++; if (all_out !== '0) begin failures++; $display("FAIL bad_opcode got=%h want=0", all_out); end
   endtask

   initial begin
      test_reset();
      test_regfile();
      test_imm();
      test_load_use();
      test_hazard_random();
      test_branch_after_load();
      test_branch_random();
      test_jal();
      test_freeze_flush();
      test_bad_opcode();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
